// File: rtl/mdio_pkg.sv
// mdio_pkg: shared state encoding, opcodes, field widths and register defaults for the MDIO responder
package mdio_pkg;
    typedef enum logic [3:0] {IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP} state_t;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int TA_W = 2;
    localparam int DATA_W = 16;
    localparam int NREGS = 32;
    localparam logic [DATA_W-1:0] REG0_DEF = 16'h1140;
    localparam logic [DATA_W-1:0] REG1_DEF = 16'h7969;
    typedef logic [NREGS-1:0][DATA_W-1:0] regfile_t;
    function automatic regfile_t reg_defaults(input logic [31:0] id);
        regfile_t r;
        r = '0;
        r[0] = REG0_DEF;
        r[1] = REG1_DEF;
        r[2] = id[31:16];
        r[3] = id[15:0];
        return r;
    endfunction
endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: 2-flop synchronizer with registered rise/fall event pulses
// Ports: clk/reset system clock and sync active-high reset; d_i asynchronous input;
//        rise_o/fall_o one-cycle pulses, 3 clk after the pin edge.
module mdio_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] s_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q    <= 3'b111;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            s_q    <= {s_q[1:0], d_i};
            rise_o <= s_q[1] & ~s_q[2];
            fall_o <= ~s_q[1] & s_q[2];
        end
    end
endmodule

// File: rtl/mdio_responder.sv
// mdio_responder: Clause 22 MDIO responder with a 32 x 16 register file
// Ports: clk/reset system clock and sync active-high reset; mdc/mdio_in from the MAC;
//        mdio_out/mdio_oen line drive (oen active-low); wr_strobe/wr_addr/wr_data report
//        committed writes; frame_err pulses on a bad start or opcode.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [PHYAD_W-1:0] PHY_ADDR     = 5'd0,
    parameter logic [31:0]        PHY_ID       = 32'h0141_0CC2,
    parameter int                 PREAMBLE_LEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mdc,
    input  logic               mdio_in,
    output logic               mdio_out,
    output logic               mdio_oen,
    output logic               wr_strobe,
    output logic [REGAD_W-1:0] wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               frame_err
);
    localparam int CW = $clog2(PREAMBLE_LEN + 1);
    localparam logic [CW-1:0] PL = CW'(PREAMBLE_LEN);
    localparam regfile_t DEFAULTS = reg_defaults(PHY_ID);

    state_t               state_q;
    logic [CW-1:0]        ones_q;
    logic [4:0]           cnt_q;
    logic [1:0]           op_q;
    logic [PHYAD_W-1:0]   phy_q;
    logic [REGAD_W-1:0]   reg_q;
    logic [DATA_W-2:0]    sh_q;
    logic [DATA_W-1:0]    rdata_q;
    regfile_t             regs_q;
    logic [1:0]           md_q;
    logic                 mdc_rise, mdc_fall, b, op_ok;
    logic [1:0]           op_d;
    logic [REGAD_W-1:0]   regad_d;
    logic [DATA_W-1:0]    wdata_d;

    mdio_sync_edge u_mdc_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (mdc),
        .rise_o (mdc_rise),
        .fall_o (mdc_fall)
    );

    assign b       = md_q[1];
    assign op_d    = {op_q[0], b};
    assign op_ok   = (op_d == OP_RD) || (op_d == OP_WR);
    assign regad_d = {reg_q[3:0], b};
    assign wdata_d = {sh_q, b};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ones_q    <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            phy_q     <= '0;
            reg_q     <= '0;
            sh_q      <= '0;
            rdata_q   <= '0;
            regs_q    <= DEFAULTS;
            md_q      <= 2'b11;
            mdio_oen  <= 1'b1;
            mdio_out  <= 1'b1;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            md_q      <= {md_q[0], mdio_in};
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (mdc_rise) begin
                case (state_q)
                    IDLE: begin
                        if (b) ones_q <= (ones_q == PL) ? PL : ones_q + 1'b1;
                        else if (ones_q == PL) begin
                            state_q <= ST;
                            ones_q  <= '0;
                            cnt_q   <= '0;
                        end else ones_q <= '0;
                    end
                    ST: begin
                        state_q   <= b ? OP : IDLE;
                        frame_err <= ~b;
                        cnt_q     <= '0;
                    end
                    OP: begin
                        op_q  <= op_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd1) begin
                            state_q   <= op_ok ? PHYAD : IDLE;
                            frame_err <= ~op_ok;
                            cnt_q     <= '0;
                        end
                    end
                    PHYAD: begin
                        phy_q <= {phy_q[3:0], b};
                        cnt_q <= (cnt_q == 5'd4) ? 5'd0 : cnt_q + 5'd1;
                        if (cnt_q == 5'd4) state_q <= REGAD;
                    end
                    REGAD: begin
                        reg_q <= regad_d;
                        cnt_q <= (cnt_q == 5'd4) ? 5'd0 : cnt_q + 5'd1;
                        if (cnt_q == 5'd4) begin
                            rdata_q <= regs_q[regad_d];
                            state_q <= (phy_q == PHY_ADDR) ? TA : SKIP;
                        end
                    end
                    // write turnaround: two bits taken on trust, data follows
                    TA: if (op_q == OP_WR) begin
                        cnt_q <= (cnt_q == 5'd1) ? 5'd0 : cnt_q + 5'd1;
                        if (cnt_q == 5'd1) state_q <= WDATA;
                    end
                    WDATA: begin
                        sh_q  <= wdata_d[DATA_W-2:0];
                        cnt_q <= (cnt_q == 5'd15) ? 5'd0 : cnt_q + 5'd1;
                        if (cnt_q == 5'd15) begin
                            state_q <= IDLE;
                            if (!(reg_q inside {5'd1, 5'd2, 5'd3})) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= reg_q;
                                wr_data   <= wdata_d;
                                // reg0 bit 15 is a self-clearing soft reset of the whole file
                                if (reg_q == 5'd0 && wdata_d[15]) regs_q <= DEFAULTS;
                                else regs_q[reg_q] <= wdata_d;
                            end
                        end
                    end
                    SKIP: begin
                        cnt_q <= (cnt_q == 5'(TA_W + DATA_W - 1)) ? 5'd0 : cnt_q + 5'd1;
                        if (cnt_q == 5'(TA_W + DATA_W - 1)) state_q <= IDLE;
                    end
                    default: ;
                endcase
            end else if (mdc_fall) begin
                case (state_q)
                    // read turnaround: first fall stays high-Z, second drives the 0
                    TA: if (op_q == OP_RD) begin
                        cnt_q <= (cnt_q == 5'd1) ? 5'd0 : cnt_q + 5'd1;
                        if (cnt_q == 5'd1) begin
                            mdio_oen <= 1'b0;
                            mdio_out <= 1'b0;
                            state_q  <= RDATA;
                        end
                    end
                    RDATA: begin
                        if (cnt_q == 5'd16) begin
                            mdio_oen <= 1'b1;
                            mdio_out <= 1'b1;
                            state_q  <= IDLE;
                            cnt_q    <= '0;
                        end else begin
                            mdio_out <= rdata_q[DATA_W-1];
                            rdata_q  <= {rdata_q[DATA_W-2:0], 1'b0};
                            cnt_q    <= cnt_q + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
